snake_body_engine: RTL and testbench

Parametrised snake movement and body engine: it replaces the fixed-size snake logic with a configurable grid, maximum length, growth step, move rate and edge mode. It holds the body as a shift array of cell coordinates and advances it one cell per move tick. It detects target capture, wall collisions and self-collisions. It also answers per-cell queries from the VGA pixel path. It sits between the master/navigation state machines (ENABLE, DIR) and the target generator, VGA controller and score counter.

---
 rtl/snake_body_engine.sv | 172 +++++++++++++++++
 tb/tb_snake_body_engine.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_engine.sv
// Snake movement and body engine: shift-array body advanced on move ticks,
// with capture, wall/self collision detection and per-cell VGA queries.
module snake_body_engine #(
    parameter int GRID_W    = 160,
    parameter int GRID_H    = 120,
    parameter int XW        = 8,
    parameter int YW        = 7,
    parameter int MAX_LEN   = 32,
    parameter int INIT_LEN  = 4,
    parameter int GROW_STEP = 2,
    parameter int TICK_DIV  = 5000000,
    parameter int WRAP_MODE = 0,
    parameter int LW        = $clog2(MAX_LEN + 1)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          ENABLE,
    input  logic          PAUSE,
    input  logic [1:0]    DIR,
    input  logic [XW-1:0] TARGET_X,
    input  logic [YW-1:0] TARGET_Y,
    input  logic [XW-1:0] QUERY_X,
    input  logic [YW-1:0] QUERY_Y,
    output logic          QUERY_HIT,
    output logic          QUERY_HEAD,
    output logic [XW-1:0] HEAD_X,
    output logic [YW-1:0] HEAD_Y,
    output logic [LW-1:0] LENGTH,
    output logic          STEP,
    output logic          TARGET_REACHED,
    output logic          DEATH
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [1:0]    dir_q, dir_eff;
    logic [LW-1:0] len_q, grow_q, len_d, grow_d;
    logic [XW-1:0] seg_x [MAX_LEN];
    logic [YW-1:0] seg_y [MAX_LEN];
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic          off, edge_hit, self_hit, collide, capture, tick, qhit;
    int            gsum;

    assign tick = (state_q == RUN) && ENABLE && !PAUSE &&
                  (cnt_q == CW'(TICK_DIV - 1));

    // Direction codes are bitwise complements of their opposites.
    always_comb begin
        dir_eff = (DIR == ~dir_q) ? dir_q : DIR;
        nx  = seg_x[0];
        ny  = seg_y[0];
        off = 1'b0;
        unique case (dir_eff)
            2'b00: if (seg_y[0] == '0) begin
                off = 1'b1;
                ny  = YW'(GRID_H - 1);
            end else ny = seg_y[0] - YW'(1);
            2'b01: if (seg_x[0] == '0) begin
                off = 1'b1;
                nx  = XW'(GRID_W - 1);
            end else nx = seg_x[0] - XW'(1);
            2'b10: if (seg_x[0] == XW'(GRID_W - 1)) begin
                off = 1'b1;
                nx  = '0;
            end else nx = seg_x[0] + XW'(1);
            default: if (seg_y[0] == YW'(GRID_H - 1)) begin
                off = 1'b1;
                ny  = '0;
            end else ny = seg_y[0] + YW'(1);
        endcase
        edge_hit = off && (WRAP_MODE == 0);
    end

    // The tail cell only counts as occupied while the body is growing.
    always_comb begin
        self_hit = 1'b0;
        qhit     = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((i + 1 < int'(len_q) || (grow_q != '0 && i < int'(len_q))) &&
                seg_x[i] == nx && seg_y[i] == ny)
                self_hit = 1'b1;
            if (i < int'(len_q) && seg_x[i] == QUERY_X && seg_y[i] == QUERY_Y)
                qhit = 1'b1;
        end
        collide = edge_hit || self_hit;
        capture = (nx == TARGET_X) && (ny == TARGET_Y);
    end

    always_comb begin
        len_d = len_q;
        gsum  = int'(grow_q);
        if (len_q == LW'(MAX_LEN)) begin
            gsum = 0;
        end else if (gsum > 0) begin
            len_d = len_q + LW'(1);
            gsum  = gsum - 1;
        end
        if (capture)
            gsum = (gsum + GROW_STEP > MAX_LEN) ? MAX_LEN : gsum + GROW_STEP;
        grow_d = LW'(gsum);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (ENABLE) state_d = RUN;
            RUN: begin
                if (!ENABLE) state_d = IDLE;
                else if (tick && collide) state_d = DEAD;
            end
            DEAD:    state_d = DEAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q          <= '0;
            dir_q          <= 2'b10;
            len_q          <= LW'(INIT_LEN);
            grow_q         <= '0;
            STEP           <= 1'b0;
            TARGET_REACHED <= 1'b0;
            DEATH          <= 1'b0;
            QUERY_HIT      <= 1'b0;
            QUERY_HEAD     <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= XW'(GRID_W / 2 - i);
                seg_y[i] <= YW'(GRID_H / 2);
            end
        end else begin
            STEP           <= 1'b0;
            TARGET_REACHED <= 1'b0;
            QUERY_HIT      <= qhit;
            QUERY_HEAD     <= (seg_x[0] == QUERY_X) && (seg_y[0] == QUERY_Y);
            if (state_q == RUN && ENABLE && !PAUSE)
                cnt_q <= tick ? '0 : cnt_q + CW'(1);
            if (tick) begin
                if (collide) begin
                    DEATH <= 1'b1;
                end else begin
                    for (int i = MAX_LEN - 1; i > 0; i--) begin
                        seg_x[i] <= seg_x[i-1];
                        seg_y[i] <= seg_y[i-1];
                    end
                    seg_x[0]       <= nx;
                    seg_y[0]       <= ny;
                    dir_q          <= dir_eff;
                    len_q          <= len_d;
                    grow_q         <= grow_d;
                    STEP           <= 1'b1;
                    TARGET_REACHED <= capture;
                end
            end
        end
    end

    assign HEAD_X = seg_x[0];
    assign HEAD_Y = seg_y[0];
    assign LENGTH = len_q;

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: a wall-mode and a wrap-mode instance share
// stimulus; directed scenarios plus random play against a queue-based model.
module tb_snake_body_engine;

    localparam int W = 8, H = 6, ML = 5, GS = 2, TD = 4;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
    } cell_t;

    logic       CLK = 1'b0;
    logic       RESET, ENABLE, PAUSE;
    logic [1:0] DIR;
    logic [2:0] TX, TY, QX, QY;
    logic [2:0] hx [2], hy [2], len [2];
    logic       step [2], tr [2], dead [2], qhit [2], qhead [2];

    int nt = 0, nf = 0;

    cell_t      body [2][$];
    int         st [2], ph [2], grow [2];
    logic [1:0] mdir [2];
    logic       e_step [2], e_tr [2], e_qhit [2], e_qhead [2];
    int         init_len [2] = '{3, 4};
    int         wrapm [2] = '{0, 1};

    always #5 CLK = ~CLK;

    snake_body_engine #(
        .GRID_W(W), .GRID_H(H), .XW(3), .YW(3), .MAX_LEN(ML), .INIT_LEN(3),
        .GROW_STEP(GS), .TICK_DIV(TD), .WRAP_MODE(0)
    ) u0 (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .PAUSE(PAUSE), .DIR(DIR),
        .TARGET_X(TX), .TARGET_Y(TY), .QUERY_X(QX), .QUERY_Y(QY),
        .QUERY_HIT(qhit[0]), .QUERY_HEAD(qhead[0]), .HEAD_X(hx[0]),
        .HEAD_Y(hy[0]), .LENGTH(len[0]), .STEP(step[0]),
        .TARGET_REACHED(tr[0]), .DEATH(dead[0])
    );

    snake_body_engine #(
        .GRID_W(W), .GRID_H(H), .XW(3), .YW(3), .MAX_LEN(ML), .INIT_LEN(4),
        .GROW_STEP(GS), .TICK_DIV(TD), .WRAP_MODE(1)
    ) u1 (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .PAUSE(PAUSE), .DIR(DIR),
        .TARGET_X(TX), .TARGET_Y(TY), .QUERY_X(QX), .QUERY_Y(QY),
        .QUERY_HIT(qhit[1]), .QUERY_HEAD(qhead[1]), .HEAD_X(hx[1]),
        .HEAD_Y(hy[1]), .LENGTH(len[1]), .STEP(step[1]),
        .TARGET_REACHED(tr[1]), .DEATH(dead[1])
    );

    task automatic model_reset(input int k);
        cell_t c;
        body[k].delete();
        for (int i = 0; i < init_len[k]; i++) begin
            c.x = 3'(W / 2 - i);
            c.y = 3'(H / 2);
            body[k].push_back(c);
        end
        st[k] = 0; ph[k] = 0; grow[k] = 0; mdir[k] = 2'b10;
        e_step[k] = 0; e_tr[k] = 0; e_qhit[k] = 0; e_qhead[k] = 0;
    endtask

    task automatic model_step(input int k, input logic [1:0] d,
                              input logic [2:0] tx, input logic [2:0] ty);
        logic [1:0] nd;
        int         nx, ny, n, old;
        bit         hit;
        cell_t      c;
        nd = (d == ~mdir[k]) ? mdir[k] : d;
        nx = int'(body[k][0].x);
        ny = int'(body[k][0].y);
        case (nd)
            2'd0:    ny--;
            2'd1:    nx--;
            2'd2:    nx++;
            default: ny++;
        endcase
        hit = (nx < 0 || nx >= W || ny < 0 || ny >= H);
        if (wrapm[k] != 0) begin
            nx = (nx + W) % W;
            ny = (ny + H) % H;
            hit = 0;
        end
        old = body[k].size();
        n = (grow[k] > 0) ? old : old - 1;
        for (int i = 0; i < n; i++)
            if (int'(body[k][i].x) == nx && int'(body[k][i].y) == ny) hit = 1;
        if (hit) begin
            st[k] = 2;
            return;
        end
        mdir[k] = nd;
        c.x = 3'(nx);
        c.y = 3'(ny);
        body[k].push_front(c);
        if (grow[k] > 0 && old < ML) grow[k]--;
        else void'(body[k].pop_back());
        if (old == ML) grow[k] = 0;
        if (nx == int'(tx) && ny == int'(ty)) begin
            e_tr[k] = 1;
            grow[k] = (grow[k] + GS > ML) ? ML : grow[k] + GS;
        end
        e_step[k] = 1;
    endtask

    task automatic model_cycle(input int k, input logic rst, input logic en,
                               input logic pa, input logic [1:0] d,
                               input logic [2:0] tx, input logic [2:0] ty,
                               input logic [2:0] qx, input logic [2:0] qy);
        if (rst) begin
            model_reset(k);
            return;
        end
        e_step[k] = 0;
        e_tr[k] = 0;
        e_qhit[k] = 0;
        e_qhead[k] = (body[k][0].x == qx) && (body[k][0].y == qy);
        for (int i = 0; i < body[k].size(); i++)
            if (body[k][i].x == qx && body[k][i].y == qy) e_qhit[k] = 1;
        case (st[k])
            0: if (en) st[k] = 1;
            1: begin
                if (!en) st[k] = 0;
                else if (!pa) begin
                    if (ph[k] == TD - 1) begin
                        ph[k] = 0;
                        model_step(k, d, tx, ty);
                    end else ph[k]++;
                end
            end
            default: ;
        endcase
    endtask

    task automatic cycle(input logic rst, input logic en, input logic pa,
                         input logic [1:0] d, input logic [2:0] tx,
                         input logic [2:0] ty, input logic [2:0] qx,
                         input logic [2:0] qy);
        RESET = rst; ENABLE = en; PAUSE = pa; DIR = d;
        TX = tx; TY = ty; QX = qx; QY = qy;
        for (int k = 0; k < 2; k++) model_cycle(k, rst, en, pa, d, tx, ty, qx, qy);
        @(posedge CLK);
        #1;
    endtask

    task automatic rst2();
        cycle(1, 0, 0, 2'b10, 0, 0, 0, 0);
        cycle(1, 0, 0, 2'b10, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        logic [13:0] got, exp;
        rst2();
        got = {hx[0], hy[0], len[0], step[0], tr[0], dead[0], qhit[0], qhead[0]};
        exp = {3'd4, 3'd3, 3'd3, 5'b0};
        nt++;
        if (got !== exp) begin
            nf++;
            $display("FAIL reset_u0: got %h exp %h", got, exp);
        end
        got = {hx[1], hy[1], len[1], step[1], tr[1], dead[1], qhit[1], qhead[1]};
        exp = {3'd4, 3'd3, 3'd4, 5'b0};
        nt++;
        if (got !== exp) begin
            nf++;
            $display("FAIL reset_u1: got %h exp %h", got, exp);
        end
    endtask

    task automatic test_wall_wrap();
        int   ns, e0x, e1x;
        logic is_step, e0s;
        rst2();
        for (int c = 1; c <= 22; c++) begin
            cycle(0, 1, 0, 2'b10, 0, 0, 0, 0);
            is_step = (c >= 5) && ((c - 5) % 4 == 0);
            ns  = (c >= 5) ? (c - 5) / 4 + 1 : 0;
            e0s = is_step && (c < 17);
            e0x = 4 + ((ns > 3) ? 3 : ns);
            e1x = (4 + ns) % W;
            nt++;
            if ({step[0], hx[0], dead[0]} !== {e0s, 3'(e0x), (c >= 17)}) begin
                nf++;
                $display("FAIL wall c%0d: step/x/death got %b/%0d/%b exp %b/%0d/%b",
                         c, step[0], hx[0], dead[0], e0s, e0x, (c >= 17));
            end
            nt++;
            if ({step[1], hx[1], dead[1]} !== {is_step, 3'(e1x), 1'b0}) begin
                nf++;
                $display("FAIL wrap c%0d: step/x/death got %b/%0d/%b exp %b/%0d/0",
                         c, step[1], hx[1], dead[1], is_step, e1x);
            end
        end
    endtask

    task automatic test_capture_growth();
        int   el;
        logic etr;
        rst2();
        for (int c = 1; c <= 22; c++) begin
            cycle(0, 1, 0, (c <= 13) ? 2'b10 : 2'b00, 5, 3, 0, 0);
            etr = (c == 5);
            el  = (c < 9) ? 3 : (c < 13) ? 4 : 5;
            nt++;
            if ({tr[0], len[0], tr[1]} !== {etr, 3'(el), etr}) begin
                nf++;
                $display("FAIL capture c%0d: tr0/len0/tr1 got %b/%0d/%b exp %b/%0d/%b",
                         c, tr[0], len[0], tr[1], etr, el, etr);
            end
        end
        nt++;
        if ({hx[0], hy[0], dead[0]} !== {3'd7, 3'd1, 1'b0}) begin
            nf++;
            $display("FAIL capture_end: x/y/death got %0d/%0d/%b exp 7/1/0",
                     hx[0], hy[0], dead[0]);
        end
    endtask

    task automatic test_opposite_dir();
        rst2();
        for (int c = 1; c <= 9; c++) cycle(0, 1, 0, 2'b01, 0, 0, 0, 0);
        nt++;
        if ({step[0], hx[0], hy[0], dead[0]} !== {1'b1, 3'd6, 3'd3, 1'b0}) begin
            nf++;
            $display("FAIL opposite: step/x/y/death got %b/%0d/%0d/%b exp 1/6/3/0",
                     step[0], hx[0], hy[0], dead[0]);
        end
    endtask

    task automatic test_self_collision();
        logic [1:0] d;
        rst2();
        for (int c = 1; c <= 25; c++) begin
            d = (c <= 13) ? 2'b10 : (c <= 17) ? 2'b00 : (c <= 21) ? 2'b01 : 2'b11;
            cycle(0, 1, 0, d, 5, 3, 0, 0);
            nt++;
            if (dead[0] !== (c >= 25)) begin
                nf++;
                $display("FAIL self_col c%0d: death got %b exp %b", c, dead[0], (c >= 25));
            end
        end
        nt++;
        if ({step[0], hx[0], hy[0], len[0]} !== {1'b0, 3'd6, 3'd2, 3'd5}) begin
            nf++;
            $display("FAIL self_col_hold: step/x/y/len got %b/%0d/%0d/%0d exp 0/6/2/5",
                     step[0], hx[0], hy[0], len[0]);
        end
    endtask

    task automatic test_tail_vacate();
        logic [1:0] d;
        rst2();
        for (int c = 1; c <= 17; c++) begin
            d = (c <= 5) ? 2'b00 : (c <= 9) ? 2'b01 : (c <= 13) ? 2'b11 : 2'b10;
            cycle(0, 1, 0, d, 0, 0, 0, 0);
            if (c == 13 || c == 17) begin
                nt++;
                if ({step[1], hx[1], hy[1], dead[1], dead[0]} !==
                    {1'b1, (c == 13) ? 3'd3 : 3'd4, 3'd3, 2'b00}) begin
                    nf++;
                    $display("FAIL tail c%0d: step/x/y/death1/death0 got %b/%0d/%0d/%b/%b",
                             c, step[1], hx[1], hy[1], dead[1], dead[0]);
                end
            end
        end
    endtask

    task automatic test_query();
        logic [2:0] qxs [4] = '{3'd4, 3'd2, 3'd1, 3'd0};
        logic [3:0] exps [4] = '{4'b1111, 4'b1010, 4'b0010, 4'b0000};
        rst2();
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 2'b10, 0, 0, qxs[i], 3);
            nt++;
            if ({qhit[0], qhead[0], qhit[1], qhead[1]} !== exps[i]) begin
                nf++;
                $display("FAIL query x%0d: hit0/head0/hit1/head1 got %b%b%b%b exp %b",
                         qxs[i], qhit[0], qhead[0], qhit[1], qhead[1], exps[i]);
            end
        end
    endtask

    task automatic test_pause();
        rst2();
        for (int c = 1; c <= 22; c++) begin
            cycle(0, 1, (c >= 6 && c <= 15), 2'b10, 0, 0, 0, 0);
            if (c >= 5) begin
                nt++;
                if (step[0] !== (c == 5 || c == 19)) begin
                    nf++;
                    $display("FAIL pause c%0d: step got %b exp %b",
                             c, step[0], (c == 5 || c == 19));
                end
            end
        end
    endtask

    task automatic test_reset_mid_step();
        rst2();
        for (int c = 1; c <= 4; c++) cycle(0, 1, 0, 2'b10, 0, 0, 0, 0);
        cycle(1, 1, 0, 2'b10, 0, 0, 0, 0);
        nt++;
        if ({step[0], hx[0], len[0]} !== {1'b0, 3'd4, 3'd3}) begin
            nf++;
            $display("FAIL mid_reset: step/x/len got %b/%0d/%0d exp 0/4/3",
                     step[0], hx[0], len[0]);
        end
        for (int c = 1; c <= 5; c++) begin
            cycle(0, 1, 0, 2'b10, 0, 0, 0, 0);
            nt++;
            if ({step[0], hx[0]} !== {(c == 5), (c == 5) ? 3'd5 : 3'd4}) begin
                nf++;
                $display("FAIL first_step c%0d: step/x got %b/%0d", c, step[0], hx[0]);
            end
        end
    endtask

    task automatic test_random();
        logic        rst, en, pa;
        logic [1:0]  d = 2'b10;
        logic [2:0]  tx, ty, qx, qy;
        logic [13:0] got, exp;
        int          j;
        for (int i = 0; i < 3000; i++) begin
            rst = (i == 0) || ($urandom_range(0, 149) == 0);
            en  = ($urandom_range(0, 15) != 0);
            pa  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 4) == 0) d = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                tx = body[0][0].x + 3'd1;
                ty = body[0][0].y;
            end else begin
                tx = 3'($urandom_range(0, W - 1));
                ty = 3'($urandom_range(0, H - 1));
            end
            if ($urandom_range(0, 1) == 0) begin
                j  = $urandom_range(0, body[1].size() - 1);
                qx = body[1][j].x;
                qy = body[1][j].y;
            end else begin
                qx = 3'($urandom_range(0, 7));
                qy = 3'($urandom_range(0, 7));
            end
            cycle(rst, en, pa, d, tx, ty, qx, qy);
            for (int k = 0; k < 2; k++) begin
                got = {hx[k], hy[k], len[k], step[k], tr[k], dead[k], qhit[k], qhead[k]};
                exp = {body[k][0].x, body[k][0].y, 3'(body[k].size()), e_step[k],
                       e_tr[k], (st[k] == 2), e_qhit[k], e_qhead[k]};
                nt++;
                if (got !== exp) begin
                    nf++;
                    $display("FAIL rand u%0d cyc %0d: got %h exp %h", k, i, got, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_wall_wrap();
        test_capture_growth();
        test_opposite_dir();
        test_self_collision();
        test_tail_vacate();
        test_query();
        test_pause();
        test_reset_mid_step();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

endmodule
